// File: rtl/proc_defs_pkg.sv
// Shared processor definitions: the 6-bit state codes the control unit decodes,
// the opcode values, and helpers used by the sequencer.
package proc_defs_pkg;

    localparam int OPW = 8;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'd0,
        ST_FETCH1 = 6'd1,
        ST_FETCH2 = 6'd2,
        ST_FETCH3 = 6'd3,
        ST_CLAC   = 6'd4,
        ST_LDAC1  = 6'd5,
        ST_LDAC2  = 6'd6,
        ST_LDAC3  = 6'd7,
        ST_STAC1  = 6'd8,
        ST_STAC2  = 6'd9,
        ST_STAC3  = 6'd10,
        ST_MVACR  = 6'd11,
        ST_MVRAC  = 6'd12,
        ST_ADD    = 6'd13,
        ST_MUL    = 6'd14
    } state_t;

    localparam int unsigned OP_CLAC  = 1;
    localparam int unsigned OP_LDAC  = 2;
    localparam int unsigned OP_STAC  = 3;
    localparam int unsigned OP_MVACR = 4;
    localparam int unsigned OP_MVRAC = 5;
    localparam int unsigned OP_ADD   = 6;
    localparam int unsigned OP_MUL   = 7;
    localparam int unsigned OP_ENDOP = 8;

    // States that retire an instruction: they pulse instr_done and sit at a boundary.
    function automatic logic is_last_exec(input state_t s);
        case (s)
            ST_CLAC, ST_LDAC3, ST_STAC3, ST_MVACR,
            ST_MVRAC, ST_ADD, ST_MUL: is_last_exec = 1'b1;
            default:                  is_last_exec = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decode: maps the opcode arriving at IR to the first
// execute state, flagging values that are not part of the instruction set.
module opcode_decoder
    import proc_defs_pkg::*;
#(
    parameter int OPW = proc_defs_pkg::OPW
) (
    input  logic [OPW-1:0] ir_next,
    output state_t         next_state,
    output logic           legal
);

    // ENDOP is legal but lands in idle, which the sequencer tells apart via legal.
    always_comb begin
        next_state = ST_IDLE;
        legal      = 1'b1;
        case (ir_next)
            OPW'(OP_CLAC):  next_state = ST_CLAC;
            OPW'(OP_LDAC):  next_state = ST_LDAC1;
            OPW'(OP_STAC):  next_state = ST_STAC1;
            OPW'(OP_MVACR): next_state = ST_MVACR;
            OPW'(OP_MVRAC): next_state = ST_MVRAC;
            OPW'(OP_ADD):   next_state = ST_ADD;
            OPW'(OP_MUL):   next_state = ST_MUL;
            OPW'(OP_ENDOP): next_state = ST_IDLE;
            default: begin
                next_state = ST_IDLE;
                legal      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/state_sequencer.sv
// Instruction-sequencing FSM: fetch, decode, execute, with start/halt handshakes,
// a retired-instruction counter and a sticky illegal-opcode flag.
module state_sequencer
    import proc_defs_pkg::*;
#(
    parameter int OPW  = proc_defs_pkg::OPW,
    parameter int CNTW = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic            halt_req,
    input  logic [OPW-1:0]  ir_next,
    output logic [5:0]      state,
    output logic            busy,
    output logic            instr_done,
    output logic            illegal,
    output logic [CNTW-1:0] instr_count
);

    state_t cur;
    state_t dec_state;
    logic   dec_legal;

    opcode_decoder #(.OPW(OPW)) u_decoder (
        .ir_next    (ir_next),
        .next_state (dec_state),
        .legal      (dec_legal)
    );

    assign state = cur;

    // busy and instr_done are computed from the state being entered so they
    // line up with the registered state code rather than trailing it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cur         <= ST_IDLE;
            busy        <= 1'b0;
            instr_done  <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            instr_done <= 1'b0;
            case (cur)
                ST_IDLE: begin
                    if (start && !illegal) begin
                        cur  <= ST_FETCH1;
                        busy <= 1'b1;
                    end
                end
                ST_FETCH1: cur <= ST_FETCH2;
                ST_FETCH2: cur <= ST_FETCH3;
                ST_FETCH3: begin
                    cur        <= dec_state;
                    instr_done <= is_last_exec(dec_state);
                    if (dec_state == ST_IDLE) begin
                        busy <= 1'b0;
                        if (dec_legal) begin
                            instr_count <= instr_count + 1'b1;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                ST_LDAC1: cur <= ST_LDAC2;
                ST_LDAC2: begin
                    cur        <= ST_LDAC3;
                    instr_done <= 1'b1;
                end
                ST_STAC1: cur <= ST_STAC2;
                ST_STAC2: begin
                    cur        <= ST_STAC3;
                    instr_done <= 1'b1;
                end
                ST_CLAC, ST_LDAC3, ST_STAC3, ST_MVACR,
                ST_MVRAC, ST_ADD, ST_MUL: begin
                    instr_count <= instr_count + 1'b1;
                    if (halt_req) begin
                        cur  <= ST_IDLE;
                        busy <= 1'b0;
                    end else begin
                        cur <= ST_FETCH1;
                    end
                end
                default: begin
                    cur  <= ST_IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
